cache_data_ram_nway: RTL

- N-way, line-organised cache data store for the DownSample cache path. It replaces the flat byte-wide data RAM.
- The CPU side has a single-word read/write port with byte enables.
- A fill side accepts a whole line from the DDR controller, one word per beat, critical word first with wrap-around.
- Fill has priority. The CPU port is stalled while a line fill is in progress.

---
 rtl/cache_data_ram_pkg.sv | 19 +
 rtl/cache_data_bank.sv | 41 ++++
 rtl/cache_data_ram_nway.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/cache_data_ram_pkg.sv
// rtl/cache_data_ram_pkg.sv - shared constants and FSM encoding for the line-organised cache data store
package cache_data_ram_pkg;

  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_INDEX_BITS  = 8;
  localparam int DEF_OFFSET_BITS = 2;
  localparam int DEF_WAYS        = 2;

  localparam int WORDS_PER_LINE = 1 << DEF_OFFSET_BITS;
  localparam int BE_WIDTH       = DEF_DATA_WIDTH / 8;
  localparam int WAY_BITS       = $clog2(DEF_WAYS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cache_data_bank.sv
// rtl/cache_data_bank.sv - single-port byte-write word array with a registered one-cycle read
module cache_data_bank
  import cache_data_ram_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int ADDR_BITS  = 11,
  localparam int BEW        = DATA_WIDTH / 8,
  localparam int DEPTH      = 1 << ADDR_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  we,
  input  logic [BEW-1:0]        be,
  input  logic [ADDR_BITS-1:0]  addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Array itself is deliberately not reset; only the read register is.
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int b = 0; b < BEW; b++) begin
        if (be[b]) begin
          mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/cache_data_ram_nway.sv
// rtl/cache_data_ram_nway.sv - N-way cache data store: CPU word port plus critical-word-first line fill
module cache_data_ram_nway
  import cache_data_ram_pkg::*;
#(
  parameter  int DATA_WIDTH  = 8 * BE_WIDTH,
  parameter  int INDEX_BITS  = DEF_INDEX_BITS,
  parameter  int OFFSET_BITS = $clog2(WORDS_PER_LINE),
  parameter  int WAYS        = 1 << WAY_BITS,
  localparam int WB          = $clog2(WAYS),
  localparam int BEW         = DATA_WIDTH / 8,
  localparam int ADDR_BITS   = WB + INDEX_BITS + OFFSET_BITS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cpu_req,
  input  logic                   cpu_write,
  input  logic [WB-1:0]          cpu_way,
  input  logic [INDEX_BITS-1:0]  cpu_index,
  input  logic [OFFSET_BITS-1:0] cpu_offset,
  input  logic [DATA_WIDTH-1:0]  cpu_wdata,
  input  logic [BEW-1:0]         cpu_byte_en,
  output logic                   cpu_ready,
  output logic [DATA_WIDTH-1:0]  cpu_rdata,
  output logic                   cpu_rvalid,
  input  logic                   fill_start,
  input  logic [WB-1:0]          fill_way,
  input  logic [INDEX_BITS-1:0]  fill_index,
  input  logic [OFFSET_BITS-1:0] fill_crit_offset,
  input  logic                   fill_valid,
  input  logic [DATA_WIDTH-1:0]  fill_data,
  output logic                   fill_ready,
  output logic                   fill_busy,
  output logic                   fill_done
);

  state_t state, state_nxt;

  logic [WB-1:0]          f_way;
  logic [INDEX_BITS-1:0]  f_index;
  logic [OFFSET_BITS-1:0] cur_off;
  logic [OFFSET_BITS-1:0] beat_cnt;
  logic                   last_beat;
  logic                   fill_wr;
  logic                   cpu_acc;

  logic                   bank_en;
  logic                   bank_we;
  logic [BEW-1:0]         bank_be;
  logic [ADDR_BITS-1:0]   bank_addr;
  logic [DATA_WIDTH-1:0]  bank_wdata;

  assign last_beat = &beat_cnt;
  assign fill_wr   = fill_ready & fill_valid;
  assign cpu_acc   = cpu_req & cpu_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cpu_ready  = 1'b0;
    fill_ready = 1'b0;
    fill_busy  = 1'b0;
    fill_done  = 1'b0;
    case (state)
      IDLE: begin
        cpu_ready = 1'b1;
        if (fill_start) state_nxt = FILL;
      end
      FILL: begin
        fill_ready = 1'b1;
        fill_busy  = 1'b1;
        if (fill_valid && last_beat) state_nxt = DONE;
      end
      DONE: begin
        fill_busy = 1'b1;
        fill_done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Fill target is captured once; later fill_start pulses cannot retarget a fill in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_way    <= '0;
      f_index  <= '0;
      cur_off  <= '0;
      beat_cnt <= '0;
    end else if (state == IDLE && fill_start) begin
      f_way    <= fill_way;
      f_index  <= fill_index;
      cur_off  <= fill_crit_offset;
      beat_cnt <= '0;
    end else if (fill_wr) begin
      cur_off  <= cur_off + OFFSET_BITS'(1);
      beat_cnt <= beat_cnt + OFFSET_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rvalid <= 1'b0;
    end else begin
      cpu_rvalid <= cpu_acc & ~cpu_write;
    end
  end

  // Fill and CPU never contend: the CPU is only accepted in IDLE, fill beats only in FILL.
  always_comb begin
    bank_en    = fill_wr | cpu_acc;
    bank_we    = fill_wr | cpu_write;
    bank_be    = cpu_byte_en;
    bank_addr  = {cpu_way, cpu_index, cpu_offset};
    bank_wdata = cpu_wdata;
    if (fill_wr) begin
      bank_be    = '1;
      bank_addr  = {f_way, f_index, cur_off};
      bank_wdata = fill_data;
    end
  end

  cache_data_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_BITS  (ADDR_BITS)
  ) u_bank (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bank_en),
    .we    (bank_we),
    .be    (bank_be),
    .addr  (bank_addr),
    .wdata (bank_wdata),
    .rdata (cpu_rdata)
  );

endmodule
